// File: rtl/mmio_uart_responder.sv
// rtl/mmio_uart_responder.sv - MMIO UART/counter responder; optional RX FIFO via MMIO_RX_FIFO_EN
module mmio_uart_responder #(
    parameter int RX_DEPTH = 8,
    parameter int RX_AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  we_i,
    input  logic        re_i,
    input  logic        inst_exec_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [31:0] rdata_o
);

    localparam logic [31:0] ADDR_STATUS = 32'h8000_0000;
    localparam logic [31:0] ADDR_RXDAT  = 32'h8000_0004;
    localparam logic [31:0] ADDR_TXDAT  = 32'h8000_0008;
    localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0010;
    localparam logic [31:0] ADDR_INSTR  = 32'h8000_0014;
    localparam logic [31:0] ADDR_CLEAR  = 32'h8000_0018;

    // Address decode (full 32-bit match)
    logic w_sel_status;
    logic w_sel_rxdat;
    logic w_sel_txdat;
    logic w_sel_cycle;
    logic w_sel_instr;
    logic w_sel_clear;
    logic w_store;

    assign w_sel_status = (addr_i == ADDR_STATUS);
    assign w_sel_rxdat  = (addr_i == ADDR_RXDAT);
    assign w_sel_txdat  = (addr_i == ADDR_TXDAT);
    assign w_sel_cycle  = (addr_i == ADDR_CYCLE);
    assign w_sel_instr  = (addr_i == ADDR_INSTR);
    assign w_sel_clear  = (addr_i == ADDR_CLEAR);
    assign w_store      = |we_i;

    // TX holding register
    logic       r_tx_valid;
    logic [7:0] r_tx_data;
    logic       w_tx_free;
    logic       w_tx_hs;
    logic       w_tx_load;

    assign w_tx_free = ~r_tx_valid;
    assign w_tx_hs   = r_tx_valid & tx_ready_i;
    // free is sampled before the handshake, so a store during the handshake is dropped
    assign w_tx_load = w_store & w_sel_txdat & w_tx_free;

    // TX holding register: load when free, release on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
        end else if (w_tx_hs) begin
            r_tx_valid <= 1'b0;
        end else if (w_tx_load) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= wdata_i[7:0];
        end
    end

    assign tx_valid_o = r_tx_valid;
    assign tx_data_o  = r_tx_data;

    // RX buffer common signals
    logic       w_rx_full;
    logic       w_rx_nonempty;
    logic [7:0] w_rx_head;
    logic       w_rx_push;
    logic       w_rx_pop;

    // a pop only happens when there is something to pop
    assign w_rx_pop = re_i & w_sel_rxdat & w_rx_nonempty;

`ifdef MMIO_RX_FIFO_EN
    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] r_rx_wptr;
    logic [RX_AW-1:0] r_rx_rptr;
    logic [RX_AW:0]   r_rx_count;

    assign w_rx_full     = (r_rx_count == (RX_AW + 1)'(RX_DEPTH));
    assign w_rx_nonempty = (r_rx_count != '0);
    assign w_rx_head     = r_rx_mem[r_rx_rptr];
    assign w_rx_push     = rx_valid_i & ~w_rx_full;

    // FIFO storage; contents are only meaningful under the occupancy count
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= rx_data_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at RX_DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + 1'b1;
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + 1'b1;
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + 1'b1;
                2'b01:   r_rx_count <= r_rx_count - 1'b1;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end
`else
    logic       r_rx_valid;
    logic [7:0] r_rx_hold;
    logic [RX_AW:0] w_unused_cfg;

    // depth parameters have no meaning for the single-entry buffer
    assign w_unused_cfg  = (RX_AW + 1)'(RX_DEPTH);
    assign w_rx_full     = r_rx_valid;
    assign w_rx_nonempty = r_rx_valid;
    assign w_rx_head     = r_rx_hold;
    // when full the pop wins: ready is low, so no push can coincide with it
    assign w_rx_push     = rx_valid_i & ~r_rx_valid;

    // single-entry RX holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_valid <= 1'b0;
            r_rx_hold  <= 8'd0;
        end else if (w_rx_push) begin
            r_rx_valid <= 1'b1;
            r_rx_hold  <= rx_data_i;
        end else if (w_rx_pop) begin
            r_rx_valid <= 1'b0;
        end
    end
`endif

    assign rx_ready_o = ~w_rx_full;

    // Cycle and instruction counters
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_inst_cnt;
    logic        w_cnt_clr;

    assign w_cnt_clr = w_store & w_sel_clear;

    // counters: clear wins over increment, both wrap at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= 32'd0;
            r_inst_cnt  <= 32'd0;
        end else if (w_cnt_clr) begin
            r_cycle_cnt <= 32'd0;
            r_inst_cnt  <= 32'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (inst_exec_i) begin
                r_inst_cnt <= r_inst_cnt + 32'd1;
            end
        end
    end

    // Read data mux, built from state before this cycle's updates
    logic [31:0] w_rd_val;

    // select read value; unmapped addresses read zero
    always_comb begin
        w_rd_val = 32'd0;
        if (w_sel_status) begin
            w_rd_val = {30'd0, w_rx_nonempty, w_tx_free};
        end else if (w_sel_rxdat) begin
            w_rd_val = {24'd0, (w_rx_nonempty ? w_rx_head : 8'd0)};
        end else if (w_sel_cycle) begin
            w_rd_val = r_cycle_cnt;
        end else if (w_sel_instr) begin
            w_rd_val = r_inst_cnt;
        end
    end

    // registered load data, held between loads
    logic [31:0] r_rdata;

    // capture read value on a load, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'd0;
        end else if (re_i) begin
            r_rdata <= w_rd_val;
        end
    end

    assign rdata_o = r_rdata;

    logic w_unused;
    assign w_unused = &{1'b0, wdata_i[31:8]};

endmodule
